// File: rtl/truth_table_sweeper_if.sv
// Bundle between truth_table_sweeper and its gate-block environment.
// Optional checker signals exist only when TT_CHECK_EN is defined.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 3
);
  localparam int unsigned TT_W = 1 << N_IN;

  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] in_vec;
  logic            busy;
  logic            done;
  logic [TT_W-1:0] tt;
  logic            tt_valid;
`ifdef TT_CHECK_EN
  logic [TT_W-1:0] exp_tt;
  logic            mismatch;
  logic [N_IN-1:0] mismatch_idx;

  // Sweeper side
  modport slave (
    input  start, dut_out, exp_tt,
    output in_vec, busy, done, tt, tt_valid, mismatch, mismatch_idx
  );
  // Environment side: requests sweeps, models the gate
  modport master (
    output start, dut_out, exp_tt,
    input  in_vec, busy, done, tt, tt_valid, mismatch, mismatch_idx
  );
`else
  // Sweeper side
  modport slave (
    input  start, dut_out,
    output in_vec, busy, done, tt, tt_valid
  );
  // Environment side: requests sweeps, models the gate
  modport master (
    output start, dut_out,
    input  in_vec, busy, done, tt, tt_valid
  );
`endif
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input combination onto a gate block in
// ascending order, waits SETTLE_CYCLES per combination, samples the gate
// output and packs the results into a truth-table word.
// Optional macro TT_CHECK_EN adds a compare against an expected table and
// reports the first failing index.
module truth_table_sweeper #(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave sw
);
  localparam int unsigned     TT_W       = 1 << N_IN;
  localparam logic [7:0]      CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] IDX_LAST   = '1;
  localparam logic [N_IN-1:0] IDX_STEP   = N_IN'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [N_IN-1:0] r_idx;
  logic [N_IN-1:0] r_in_vec;
  logic [7:0]      r_cnt;
  logic [TT_W-1:0] r_tt;
  logic            r_tt_valid;
`ifdef TT_CHECK_EN
  logic            r_mismatch;
  logic [N_IN-1:0] r_mismatch_idx;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode; start is only looked at in IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (sw.start) w_state_next = S_SETTLE;
      S_SETTLE: if (r_cnt == '0) w_state_next = S_SAMPLE;
      S_SAMPLE: w_state_next = (r_idx == IDX_LAST) ? S_DONE : S_SETTLE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Sweep datapath: index, gate drive, settle counter, captured table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx          <= '0;
      r_in_vec       <= '0;
      r_cnt          <= '0;
      r_tt           <= '0;
      r_tt_valid     <= 1'b0;
`ifdef TT_CHECK_EN
      r_mismatch     <= 1'b0;
      r_mismatch_idx <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sw.start) begin
            r_idx          <= '0;
            r_in_vec       <= '0;
            r_cnt          <= CNT_RELOAD;
            r_tt           <= '0;
            r_tt_valid     <= 1'b0;
`ifdef TT_CHECK_EN
            r_mismatch     <= 1'b0;
            r_mismatch_idx <= '0;
`endif
          end
        end
        S_SETTLE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 8'd1;
        end
        S_SAMPLE: begin
          r_tt[r_idx] <= sw.dut_out;
`ifdef TT_CHECK_EN
          // Keep the first failing index only
          if ((sw.dut_out != sw.exp_tt[r_idx]) && !r_mismatch) begin
            r_mismatch     <= 1'b1;
            r_mismatch_idx <= r_idx;
          end
`endif
          if (r_idx != IDX_LAST) begin
            r_idx    <= r_idx + IDX_STEP;
            r_in_vec <= r_idx + IDX_STEP;
            r_cnt    <= CNT_RELOAD;
          end
        end
        S_DONE: begin
          r_tt_valid <= 1'b1;
          r_in_vec   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign sw.in_vec   = r_in_vec;
  assign sw.busy     = (r_state != S_IDLE);
  assign sw.done     = (r_state == S_DONE);
  assign sw.tt       = r_tt;
  assign sw.tt_valid = r_tt_valid;
`ifdef TT_CHECK_EN
  assign sw.mismatch     = r_mismatch;
  assign sw.mismatch_idx = r_mismatch_idx;
`endif

endmodule
